// File: rtl/clk_divider_prog_if.sv
// -----------------------------------------------------------------------------
// clk_divider_prog_if
//
// Configuration bus for clk_divider_prog.
//
// Handshake: the master raises cfg_valid together with cfg_ch / cfg_div /
// cfg_high and holds them stable while cfg_valid is high. A request is
// accepted on a rising clock edge where cfg_valid and cfg_ready are both
// high. cfg_ready is combinational from cfg_ch: it is low only while the
// addressed (existing) channel still holds an unapplied configuration.
// An accepted request that names a non-existent channel or a zero divisor
// is dropped, and cfg_err pulses for one cycle after the accepting edge.
//
// Signals:
//   cfg_valid  master -> slave  request present
//   cfg_ready  slave  -> master request can be taken this cycle
//   cfg_ch     master -> slave  target channel
//   cfg_div    master -> slave  new divisor (period in clock cycles)
//   cfg_high   master -> slave  new high-phase length in clock cycles
//   cfg_err    slave  -> master one-cycle pulse: accepted request rejected
// -----------------------------------------------------------------------------
interface clk_divider_prog_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 28
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_high,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_high,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clk_divider_prog.sv
// -----------------------------------------------------------------------------
// clk_divider_prog
//
// Multi-channel programmable divided-clock / tick generator. Every channel
// counts clock_in cycles modulo its active divisor D and produces a
// registered divided clock (high for the first H cycles of each period)
// plus a one-cycle tick at the start of each period. New settings arrive
// over the configuration bus, are parked in a per-channel shadow, and are
// only copied into the active settings at a period boundary (or at once
// while the channel is stopped), so the outputs never glitch.
//
// Ports:
//   clock_in   system clock, all logic on its rising edge
//   reset_in   synchronous active-high reset
//   ch_en      per-channel run enable (level), ANDed with the internal mask
//   sync_in    one-cycle pulse: restart every running channel at count 0
//   cfg        configuration bus (slave side of clk_divider_prog_if)
//   clock_out  divided clocks, registered
//   tick_out   period-start pulses, registered
//   pend_out   channel holds a configuration not yet applied
// -----------------------------------------------------------------------------
module clk_divider_prog #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 4,
  parameter int DEFAULT_EN  = 0
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_in,
  clk_divider_prog_if.slave cfg,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] pend_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_DIV / 2);
  // One extra bit so NUM_CH itself is representable when NUM_CH is a
  // power of two and cfg_ch cannot reach it.
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);
  localparam logic             RST_EN   = (DEFAULT_EN != 0);

  // ---------------------------------------------------------------------------
  // Configuration request decode (shared by all channels)
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] pend_w;
  logic              ready;
  logic              ch_in_range;
  logic              accept;
  logic              bad_req;
  logic              store;
  logic [CNT_W-1:0]  high_clamped;
  logic              err_q;
  logic              err_d;

  assign ch_in_range = ({1'b0, cfg.cfg_ch} < CH_LIMIT);

  // Only an existing channel with a config still in its shadow can stall
  // the bus; out-of-range requests are always taken so they can be
  // reported through cfg_err instead of hanging the master.
  always_comb begin
    ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        ready = ~pend_w[i];
      end
    end
  end

  assign accept  = cfg.cfg_valid & ready;
  assign bad_req = (cfg.cfg_div == '0) | ~ch_in_range;
  assign store   = accept & ~bad_req;

  // A high phase longer than the period just means "always high".
  assign high_clamped = (cfg.cfg_high > cfg.cfg_div) ? cfg.cfg_div : cfg.cfg_high;

  assign err_d = accept & bad_req;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = err_q;

  // ---------------------------------------------------------------------------
  // Per-channel divider
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] div_a_q,  div_a_d;
    logic [CNT_W-1:0] high_a_q, high_a_d;
    logic [CNT_W-1:0] div_p_q,  div_p_d;
    logic [CNT_W-1:0] high_p_q, high_p_d;
    logic             pend_q,   pend_d;
    logic             mask_q;
    logic             clk_q,    clk_d;
    logic             tick_q,   tick_d;
    logic             run;
    logic             boundary;
    logic             apply;
    logic             sel;

    assign run = ch_en[g] & mask_q;

    // ">=" rather than "==" so a count left beyond a freshly shortened
    // divisor still wraps instead of running through the whole counter.
    // div_a_q is never zero (reset value >= 1, zero divisors are rejected).
    assign boundary = sync_in | (cnt_q >= (div_a_q - CNT_W'(1)));

    // A stopped channel has no waveform to protect, so its shadow is
    // copied straight away.
    assign apply = pend_q & (~run | boundary);

    assign sel = store & (cfg.cfg_ch == CH_W'(g));

    always_comb begin
      cnt_d    = cnt_q;
      div_a_d  = div_a_q;
      high_a_d = high_a_q;
      div_p_d  = div_p_q;
      high_p_d = high_p_q;
      pend_d   = pend_q;

      // Outputs reflect the count present before this edge, giving the
      // one-cycle latency and putting the rising edge on the tick.
      clk_d  = run & (cnt_q < high_a_q);
      tick_d = run & (cnt_q == '0);

      if (run && !boundary) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end

      if (apply) begin
        div_a_d  = div_p_q;
        high_a_d = high_p_q;
        pend_d   = 1'b0;
      end

      // sel requires pend_q == 0 (ready), so it never collides with apply.
      if (sel) begin
        div_p_d  = cfg.cfg_div;
        high_p_d = high_clamped;
        pend_d   = 1'b1;
      end
    end

    always_ff @(posedge clock_in) begin
      if (reset_in) begin
        cnt_q    <= '0;
        div_a_q  <= RST_DIV;
        high_a_q <= RST_HIGH;
        div_p_q  <= RST_DIV;
        high_p_q <= RST_HIGH;
        pend_q   <= 1'b0;
        mask_q   <= RST_EN;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_a_q  <= div_a_d;
        high_a_q <= high_a_d;
        div_p_q  <= div_p_d;
        high_p_q <= high_p_d;
        pend_q   <= pend_d;
        // The internal enable mask has no write path; it holds its reset value.
        mask_q   <= mask_q;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign pend_w[g]    = pend_q;
    assign clock_out[g] = clk_q;
    assign tick_out[g]  = tick_q;
    assign pend_out[g]  = pend_q;
  end

endmodule
